// File: rtl/cpu_dbg_pkg.sv
// Shared types and constants for the CPU debug/performance dump unit.
package cpu_dbg_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SEND_CYC,
      SEND_INS,
      FETCH,
      SEND_REG
   } dump_state_e;

   localparam int unsigned HDR_WORDS = 2;
   localparam int unsigned CYC_IDX   = 0;
   localparam int unsigned INS_IDX   = 1;

endpackage

// File: rtl/perf_counter.sv
// Saturating event counter with synchronous active-low clear.
module perf_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_count <= '0;
      end else if (inc && (r_count != '1)) begin
         r_count <= r_count + CNT_W'(1);
      end
   end

   assign count = r_count;

endmodule

// File: rtl/cpu_dump_unit.sv
// Streams a cycle/instruction counter snapshot followed by every architectural
// register over a valid/ready port; the register file is read via rf_raddr/rf_rdata.
module cpu_dump_unit
   import cpu_dbg_pkg::*;
#(
   parameter  int NUM_REGS = 32,
   parameter  int DATA_W   = 32,
   parameter  int CNT_W    = 32,
   localparam int AW       = $clog2(NUM_REGS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              instr_retire,
   input  logic              dump_req,
   output logic [AW-1:0]     rf_raddr,
   input  logic [DATA_W-1:0] rf_rdata,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic              busy
);

   localparam logic [AW-1:0] LAST_IDX = AW'(NUM_REGS - 1);

   logic [CNT_W-1:0] w_cyc_cnt;
   logic [CNT_W-1:0] w_ins_cnt;

   perf_counter #(.CNT_W(CNT_W)) u_cyc_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (1'b1),
      .count (w_cyc_cnt)
   );

   perf_counter #(.CNT_W(CNT_W)) u_ins_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (instr_retire),
      .count (w_ins_cnt)
   );

   dump_state_e       r_state,    w_state_nxt;
   logic [AW-1:0]     r_idx,      w_idx_nxt;
   logic [CNT_W-1:0]  r_ins_snap, w_ins_snap_nxt;
   logic [DATA_W-1:0] r_data,     w_data_nxt;
   logic              r_valid,    w_valid_nxt;
   logic              r_last,     w_last_nxt;
   logic              r_busy,     w_busy_nxt;
   logic              w_hs;

   assign w_hs = r_valid & out_ready;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state    <= IDLE;
         r_idx      <= '0;
         r_ins_snap <= '0;
         r_data     <= '0;
         r_valid    <= 1'b0;
         r_last     <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_idx      <= w_idx_nxt;
         r_ins_snap <= w_ins_snap_nxt;
         r_data     <= w_data_nxt;
         r_valid    <= w_valid_nxt;
         r_last     <= w_last_nxt;
         r_busy     <= w_busy_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_idx_nxt      = r_idx;
      w_ins_snap_nxt = r_ins_snap;
      w_data_nxt     = r_data;
      w_valid_nxt    = r_valid;
      w_last_nxt     = r_last;
      w_busy_nxt     = r_busy;

      case (r_state)
         IDLE: begin
            // Both counters captured on the same edge; the instr value waits in r_ins_snap.
            if (dump_req) begin
               w_data_nxt     = DATA_W'(w_cyc_cnt);
               w_ins_snap_nxt = w_ins_cnt;
               w_valid_nxt    = 1'b1;
               w_busy_nxt     = 1'b1;
               w_state_nxt    = SEND_CYC;
            end
         end
         SEND_CYC: begin
            if (w_hs) begin
               w_data_nxt  = DATA_W'(r_ins_snap);
               w_state_nxt = SEND_INS;
            end
         end
         SEND_INS: begin
            if (w_hs) begin
               w_idx_nxt   = '0;
               w_valid_nxt = 1'b0;
               w_state_nxt = FETCH;
            end
         end
         FETCH: begin
            w_data_nxt  = rf_rdata;
            w_valid_nxt = 1'b1;
            w_last_nxt  = (r_idx == LAST_IDX);
            w_state_nxt = SEND_REG;
         end
         SEND_REG: begin
            if (w_hs) begin
               w_valid_nxt = 1'b0;
               if (r_last) begin
                  w_last_nxt  = 1'b0;
                  w_busy_nxt  = 1'b0;
                  w_state_nxt = IDLE;
               end else begin
                  w_idx_nxt   = r_idx + AW'(1);
                  w_state_nxt = FETCH;
               end
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   assign rf_raddr  = r_idx;
   assign out_valid = r_valid;
   assign out_data  = r_data;
   assign out_last  = r_last;
   assign busy      = r_busy;

endmodule
